// File: rtl/noise_level_sched_pkg.sv
// Shared types and widths for the AWGN noise-level scheduler.
package noise_level_sched_pkg;

  localparam int NOISE_MAG_WIDTH = 8;
  localparam int DROP_WIDTH      = 8;
  localparam int STATS_WIDTH     = 16;

  typedef enum logic [0:0] {NS_SETTLE, NS_DWELL} noise_sched_state_t;

  typedef logic [1:0] noise_sel_t;

endpackage

// File: rtl/noise_level_sched_if.sv
// Control/status bundle between the noise scheduler and its surroundings.
// Optional stats outputs appear only when NOISE_SCHED_STATS_EN is defined.
interface noise_level_sched_if;
  import noise_level_sched_pkg::*;

  logic                       btn_press;
  logic                       auto_en;
  logic                       sym_valid;
  logic                       demod_lock;
  logic [NOISE_MAG_WIDTH-1:0] noise_magnitude;
  noise_sel_t                 noise_sel;
  logic                       level_change;
  logic                       settled;
  logic                       lock_fail;
  logic [DROP_WIDTH-1:0]      lock_drops;
`ifdef NOISE_SCHED_STATS_EN
  logic [STATS_WIDTH-1:0]     lock_syms;
  logic [STATS_WIDTH-1:0]     last_lock_syms;
`endif

  modport master (
    output btn_press, auto_en, sym_valid, demod_lock,
`ifdef NOISE_SCHED_STATS_EN
    input  lock_syms, last_lock_syms,
`endif
    input  noise_magnitude, noise_sel, level_change, settled, lock_fail, lock_drops
  );

  modport slave (
    input  btn_press, auto_en, sym_valid, demod_lock,
`ifdef NOISE_SCHED_STATS_EN
    output lock_syms, last_lock_syms,
`endif
    output noise_magnitude, noise_sel, level_change, settled, lock_fail, lock_drops
  );

endinterface

// File: rtl/noise_level_sched_stats.sv
// Saturating count of locked symbols within one DWELL, latched on every level advance.
module noise_sched_stats
  import noise_level_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   count_en,
  input  logic                   latch,
  output logic [STATS_WIDTH-1:0] lock_syms,
  output logic [STATS_WIDTH-1:0] last_lock_syms
);

  logic [STATS_WIDTH-1:0] cnt_q;
  logic [STATS_WIDTH-1:0] last_q;

  // An advance both snapshots the running count and starts a fresh one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else if (latch) begin
      last_q <= cnt_q;
      cnt_q  <= '0;
    end else if (count_en && (cnt_q != {STATS_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lock_syms      = cnt_q;
  assign last_lock_syms = last_q;

endmodule

// File: rtl/noise_level_sched.sv
// AWGN noise-level sequencer: manual step or auto-sweep gated on Costas lock settling.
// Optional lock statistics are built when NOISE_SCHED_STATS_EN is defined.
module noise_level_sched
  import noise_level_sched_pkg::*;
#(
  parameter logic [NOISE_MAG_WIDTH-1:0] LEVEL0       = 8'd0,
  parameter logic [NOISE_MAG_WIDTH-1:0] LEVEL1       = 8'd20,
  parameter logic [NOISE_MAG_WIDTH-1:0] LEVEL2       = 8'd50,
  parameter logic [NOISE_MAG_WIDTH-1:0] LEVEL3       = 8'd100,
  parameter int unsigned                SETTLE_SYMS  = 256,
  parameter int unsigned                TIMEOUT_SYMS = 4096,
  parameter int unsigned                DWELL_SYMS   = 65536
) (
  input logic                clk,
  input logic                rst,
  noise_level_sched_if.slave bus
);

  localparam int RUN_W   = $clog2(SETTLE_SYMS) + 1;
  localparam int TMO_W   = $clog2(TIMEOUT_SYMS) + 1;
  localparam int DWELL_W = $clog2(DWELL_SYMS) + 1;

  localparam logic [RUN_W-1:0]   RUN_DONE  = RUN_W'(SETTLE_SYMS);
  localparam logic [TMO_W-1:0]   TMO_DONE  = TMO_W'(TIMEOUT_SYMS);
  localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(DWELL_SYMS - 1);

  noise_sched_state_t         state;
  noise_sel_t                 sel_q;
  logic [NOISE_MAG_WIDTH-1:0] mag_q;
  logic                       level_change_q;
  logic                       lock_fail_q;
  logic [DROP_WIDTH-1:0]      drops_q;
  logic [RUN_W-1:0]           lock_run;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [DWELL_W-1:0]         dwell_cnt;
  logic                       prev_lock;

  logic                       auto_expiry;
  logic                       advance;
  noise_sel_t                 next_sel;
  logic [RUN_W-1:0]           run_next;
  logic [TMO_W-1:0]           tmo_next;
  logic                       lock_drop;

  function automatic logic [NOISE_MAG_WIDTH-1:0] level_of(input noise_sel_t s);
    case (s)
      2'd0:    level_of = LEVEL0;
      2'd1:    level_of = LEVEL1;
      2'd2:    level_of = LEVEL2;
      default: level_of = LEVEL3;
    endcase
  endfunction

  // Button and auto expiry share one advance so a coincident pair steps only once.
  always_comb begin
    auto_expiry = (state == NS_DWELL) && bus.auto_en && bus.sym_valid &&
                  (dwell_cnt == DWELL_END);
    advance     = bus.btn_press || auto_expiry;
    next_sel    = sel_q + 2'd1;
    run_next    = bus.demod_lock ? (lock_run + 1'b1) : '0;
    tmo_next    = tmo_cnt + 1'b1;
    lock_drop   = (state == NS_DWELL) && bus.sym_valid && prev_lock && !bus.demod_lock;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= NS_SETTLE;
      sel_q          <= '0;
      mag_q          <= LEVEL0;
      level_change_q <= 1'b0;
      lock_fail_q    <= 1'b0;
      drops_q        <= '0;
      lock_run       <= '0;
      tmo_cnt        <= '0;
      dwell_cnt      <= '0;
      prev_lock      <= 1'b0;
    end else begin
      level_change_q <= 1'b0;
      if (bus.sym_valid) begin
        prev_lock <= bus.demod_lock;
      end
      if (advance) begin
        sel_q          <= next_sel;
        mag_q          <= level_of(next_sel);
        level_change_q <= 1'b1;
        state          <= NS_SETTLE;
        lock_run       <= '0;
        tmo_cnt        <= '0;
        dwell_cnt      <= '0;
        drops_q        <= '0;
        lock_fail_q    <= 1'b0;
      end else begin
        case (state)
          NS_SETTLE: begin
            if (bus.sym_valid) begin
              lock_run <= run_next;
              tmo_cnt  <= tmo_next;
              // A completed lock run wins over a timeout landing on the same symbol.
              if (run_next == RUN_DONE) begin
                state <= NS_DWELL;
              end else if (tmo_next == TMO_DONE) begin
                lock_fail_q <= 1'b1;
                state       <= NS_DWELL;
              end
            end
          end
          NS_DWELL: begin
            if (bus.sym_valid) begin
              if (dwell_cnt != DWELL_END) begin
                dwell_cnt <= dwell_cnt + 1'b1;
              end
              if (lock_drop && (drops_q != {DROP_WIDTH{1'b1}})) begin
                drops_q <= drops_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.noise_magnitude = mag_q;
  assign bus.noise_sel       = sel_q;
  assign bus.level_change    = level_change_q;
  assign bus.settled         = (state == NS_DWELL);
  assign bus.lock_fail       = lock_fail_q;
  assign bus.lock_drops      = drops_q;

`ifdef NOISE_SCHED_STATS_EN
  logic stats_count;
  assign stats_count = (state == NS_DWELL) && bus.sym_valid && bus.demod_lock && !advance;

  noise_sched_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .count_en       (stats_count),
    .latch          (advance),
    .lock_syms      (bus.lock_syms),
    .last_lock_syms (bus.last_lock_syms)
  );
`endif

endmodule

// File: tb/tb_noise_level_sched.sv
// Randomized plus directed scoreboard bench for noise_level_sched against a behavioural model.
module tb_noise_level_sched;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int DWELL   = 16;

  typedef struct {
    int mag;
    int sel;
    bit lc;
    bit settled;
    bit fail;
    int drops;
  } exp_t;

  logic clk;
  logic rst;
  noise_level_sched_if nif();

  noise_level_sched #(
    .SETTLE_SYMS  (SETTLE),
    .TIMEOUT_SYMS (TIMEOUT),
    .DWELL_SYMS   (DWELL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   levels [4] = '{0, 20, 50, 100};
  exp_t exp_q [$];
  int   level_q [$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: plain integers following the level/settle/dwell rules.
  int m_sel, m_run, m_tmo, m_dwell, m_drops;
  bit m_in_dwell, m_fail, m_prev, m_lc;

  task automatic modelStep(input bit r, input bit b, input bit a, input bit sv, input bit lk);
    bit expiry, ev;
    if (r) begin
      m_sel = 0; m_run = 0; m_tmo = 0; m_dwell = 0; m_drops = 0;
      m_in_dwell = 0; m_fail = 0; m_prev = 0; m_lc = 0;
      return;
    end
    expiry = m_in_dwell && a && sv && (m_dwell >= DWELL - 1);
    ev     = b || expiry;
    m_lc   = ev;
    if (ev) begin
      m_sel = (m_sel + 1) % 4;
      m_in_dwell = 0; m_run = 0; m_tmo = 0; m_dwell = 0; m_drops = 0; m_fail = 0;
    end else if (!m_in_dwell) begin
      if (sv) begin
        m_run = lk ? m_run + 1 : 0;
        m_tmo = m_tmo + 1;
        if (m_run == SETTLE) m_in_dwell = 1;
        else if (m_tmo == TIMEOUT) begin
          m_fail = 1;
          m_in_dwell = 1;
        end
      end
    end else if (sv) begin
      if (m_prev && !lk && m_drops < 255) m_drops++;
      if (m_dwell < DWELL - 1) m_dwell++;
    end
    if (sv) m_prev = lk;
  endtask

  task automatic applyStimulus(input bit r, input bit b, input bit a, input bit sv, input bit lk);
    exp_t e;
    rst            = r;
    nif.btn_press  = b;
    nif.auto_en    = a;
    nif.sym_valid  = sv;
    nif.demod_lock = lk;
    modelStep(r, b, a, sv, lk);
    @(posedge clk);
    e.mag = levels[m_sel]; e.sel = m_sel; e.lc = m_lc;
    e.settled = m_in_dwell; e.fail = m_fail; e.drops = m_drops;
    exp_q.push_back(e);
    if (m_lc) level_q.push_back(levels[m_sel]);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (int'(nif.noise_magnitude) != e.mag || int'(nif.noise_sel) != e.sel ||
        nif.level_change != e.lc || nif.settled != e.settled ||
        nif.lock_fail != e.fail || int'(nif.lock_drops) != e.drops) begin
      errors++;
      $display("[TB] FAIL snapshot t=%0t got mag=%0d sel=%0d lc=%0b settled=%0b fail=%0b drops=%0d required mag=%0d sel=%0d lc=%0b settled=%0b fail=%0b drops=%0d",
               $time, nif.noise_magnitude, nif.noise_sel, nif.level_change, nif.settled,
               nif.lock_fail, nif.lock_drops, e.mag, e.sel, e.lc, e.settled, e.fail, e.drops);
    end
  endtask

  // Monitor: per-cycle snapshot compare plus a level-table compare on each level_change.
  initial begin
    exp_t e;
    int   lv;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
      if (nif.level_change === 1'b1) begin
        checks++;
        if (level_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL level_pulse t=%0t got unexpected level_change with mag=%0d required no pulse",
                   $time, nif.noise_magnitude);
        end else begin
          lv = level_q.pop_front();
          if (int'(nif.noise_magnitude) != lv) begin
            errors++;
            $display("[TB] FAIL level_value t=%0t got mag=%0d required %0d", $time, nif.noise_magnitude, lv);
          end
        end
      end
    end
  end

  initial begin
    bit lk, au, found;
    int guard;
    rst = 1'b1;
    nif.btn_press = 0; nif.auto_en = 0; nif.sym_valid = 0; nif.demod_lock = 0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Lock held, symbol every cycle: settle after SETTLE symbols.
    for (int i = 0; i < SETTLE + 4; i++) applyStimulus(0, 0, 0, 1, 1);

    // Auto-sweep through all four levels and wrap.
    for (int i = 0; i < 5 * (SETTLE + DWELL) + 10; i++) applyStimulus(0, 0, 1, 1, 1);

    // Lock absent through SETTLE: timeout, then button clears lock_fail.
    applyStimulus(0, 1, 0, 1, 0);
    for (int i = 0; i < TIMEOUT + 3; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Button coincident with auto expiry.
    found = 0;
    for (guard = 0; guard < 300; guard++) begin
      if (m_in_dwell && m_dwell == DWELL - 1) begin
        found = 1;
        break;
      end
      applyStimulus(0, 0, 1, 1, 1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL coincident_search got no expiry window required one within 300 cycles");
    end
    applyStimulus(0, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Lock drops in DWELL: three, then saturation.
    for (guard = 0; guard < 100 && !m_in_dwell; guard++) applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 0);
    end

    // Reset mid-DWELL at level 2.
    for (guard = 0; guard < 4 && m_sel != 2; guard++) applyStimulus(0, 1, 0, 1, 1);
    for (guard = 0; guard < 100 && !m_in_dwell; guard++) applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);

    // Randomized traffic.
    lk = 1; au = 1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 19) == 0) lk = !lk;
      if ($urandom_range(0, 299) == 0) au = !au;
      applyStimulus($urandom_range(0, 2999) == 0, $urandom_range(0, 149) == 0, au,
                    $urandom_range(0, 3) != 0, lk);
    end
    applyStimulus(0, 0, au, 0, lk);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || level_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got exp_q=%0d level_q=%0d required 0 and 0", exp_q.size(), level_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
